farm_vehicle_detector: RTL and testbench
========================================

Name: farm_vehicle_detector

Overview:
- Farm-road vehicle detector; drives the `sensor` input of the traffic-light controller `state_machine`.
- Conditions the raw inductive-loop input and keeps a count of queued farm-road vehicles.
- Watches `light_farm` to retire vehicles while the farm road is green; `sensor` stays high while any vehicle waits.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples needed to accept a loop level change (min 2).
- CNT_W, 4, width of vehicle counter; saturates at 2**CNT_W-1.
- PASS_CYCLES, 8, clk cycles of farm green needed to retire one vehicle (min 1).
- MAX_WAIT, 64, cycles `sensor` may stay high with farm not green before alarm (WAIT_TIMEOUT_EN only).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- loop_raw  input  1  raw loop detector, asynchronous to clk, may bounce.
- light_farm  input  3  farm light from controller: RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- sensor  output  1  vehicle waiting on farm road (to controller).
- vehicle_count  output  CNT_W  vehicles currently queued.
- overflow  output  1  sticky; arrival seen while count saturated.
- illegal_light  output  1  sticky; light_farm not one of the three legal codes.
- wait_alarm  output  1  starvation alarm; present only with WAIT_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release): vehicle_count=0, sensor=0, overflow=0, illegal_light=0, wait_alarm=0, pass timer=0, debounce FSM=IDLE, sync flops=0.
- Synchronizer: loop_raw passes through 2 flops (s2) before any use.
- Debounce FSM states:
  - IDLE: s2=1 -> QUAL_ON with cnt=1.
  - QUAL_ON: s2=0 -> IDLE. When cnt reaches DEBOUNCE_CYCLES -> PRESENT and a one-cycle arrive pulse.
  - PRESENT: s2=0 -> QUAL_OFF with cnt=1.
  - QUAL_OFF: s2=1 -> PRESENT. When cnt reaches DEBOUNCE_CYCLES -> IDLE.
- Arrival latency: vehicle_count increments on the (DEBOUNCE_CYCLES+2)th clk edge after loop_raw rises and stays high.
- Glitch rejection: a high or low glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no arrival.
- Pass timer:
  - Runs only while light_farm==GREEN and vehicle_count>0.
  - Counts 0..PASS_CYCLES-1. At terminal, a depart event occurs and the timer restarts at 0.
  - Cleared to 0 whenever farm is not GREEN or count==0. YELLOW does not retire vehicles.
- Counter update, per cycle:
  - arrive only: +1. If the count is already at max, hold and set overflow.
  - depart only: -1. The count never goes below 0.
  - arrive and depart together: count unchanged, no overflow.
- sensor is registered and equals (vehicle_count!=0) after each update, so it falls the same edge the count reaches 0.
- illegal_light: set on any edge where light_farm is not 100/010/001. The illegal value is treated as not-GREEN. Cleared only by reset.
- Reset mid-qualification or mid-pass discards partial counts. A vehicle already on the loop at reset release is counted once after debounce.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- Defined:
  - Wait counter increments each cycle with sensor=1 and light_farm!=GREEN.
  - Clears when farm is GREEN or sensor=0.
  - wait_alarm asserts when the counter reaches MAX_WAIT and stays high until farm GREEN or reset.
- Undefined: the wait_alarm port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package traffic_pkg:
  - Light encodings LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN.
  - Debounce state enum (IDLE, QUAL_ON, PRESENT, QUAL_OFF).
- Sub-module loop_debouncer:
  - Contains the synchronizer, debounce FSM and counter.
  - Outputs the arrive pulse and debounced level.
- Top-level farm_vehicle_detector: counter, pass timer, flags, wait timer.

Test Plan:
- Reset: rst_n=0 with loop_raw=1, light_farm=100 -> sensor=0, vehicle_count=0. Release -> count=1 on edge 6 after release.
- Glitch reject: loop_raw high 3 cycles then low, defaults -> vehicle_count stays 0, sensor stays 0.
- Queue and retire:
  - Stimulus: three clean pulses (10 cycles high, 10 low), light_farm=100 -> count=3, sensor=1.
  - Then light_farm=001 for 24 cycles -> count decrements every 8 cycles to 0, and sensor falls on the edge count reaches 0.
- Saturation: 16 clean arrivals, farm RED -> count holds at 15 and overflow=1 after the 16th. Remains after light_farm=001 drains the count to 0.
- Simultaneous: farm GREEN, count=2, arrive on the same edge as the pass-timer terminal -> count stays 2.
- Illegal light plus WAIT_TIMEOUT_EN:
  - light_farm=3'b011 -> illegal_light=1 and no retirement occurs.
  - With count=1 and farm RED for 64 cycles -> wait_alarm=1. It clears on light_farm=001.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the farm-road vehicle detector and the traffic-light
// controller it feeds: light encodings and the loop debounce state type.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL_ON  = 2'd1,
        PRESENT  = 2'd2,
        QUAL_OFF = 2'd3
    } db_state_e;

endpackage

// File: rtl/loop_debouncer.sv
// loop_debouncer
// Synchronizes the raw inductive-loop input and debounces it with a small FSM.
//
// State table:
//   state    | meaning
//   IDLE     | no vehicle on the loop
//   QUAL_ON  | loop high, counting consecutive high samples
//   PRESENT  | vehicle accepted and sitting on the loop
//   QUAL_OFF | loop low, counting consecutive low samples
//
// Ports:
//   clk       in   system clock
//   rst_n     in   async active-low reset
//   loop_raw  in   raw loop level, asynchronous, may bounce
//   arrive    out  one-cycle pulse on the edge a vehicle is accepted
//   level     out  debounced loop level
module loop_debouncer
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic loop_raw,
    output logic arrive,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    db_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= loop_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds the number of qualifying samples already seen; the sample
    // being taken this edge is the DEBOUNCE_CYCLES-th when cnt_q == CNT_LAST,
    // so arrive is decoded combinationally and the top counts it this edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arrive  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = QUAL_ON;
                    cnt_d   = CW'(1);
                end
            end
            QUAL_ON: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESENT;
                    cnt_d   = '0;
                    arrive  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESENT: begin
                if (!s2_q) begin
                    state_d = QUAL_OFF;
                    cnt_d   = CW'(1);
                end
            end
            QUAL_OFF: begin
                if (s2_q) begin
                    state_d = PRESENT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = (state_q == PRESENT) || (state_q == QUAL_OFF);

endmodule

// File: rtl/farm_vehicle_detector.sv
// farm_vehicle_detector
// Counts farm-road vehicles queued at the loop and retires them while the farm
// light is green; drives the controller's sensor input.
// Optional macro WAIT_TIMEOUT_EN adds a starvation alarm (wait_alarm).
//
// Ports:
//   clk            in   system clock
//   rst_n          in   async active-low reset
//   loop_raw       in   raw loop detector
//   light_farm     in   farm light (RED=100, YELLOW=010, GREEN=001)
//   sensor         out  vehicle waiting on farm road
//   vehicle_count  out  vehicles currently queued
//   overflow       out  sticky, arrival seen while count saturated
//   illegal_light  out  sticky, light_farm held an illegal code
//   wait_alarm     out  starvation alarm (WAIT_TIMEOUT_EN only)
module farm_vehicle_detector
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned PASS_CYCLES     = 8,
    parameter int unsigned MAX_WAIT        = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loop_raw,
    input  logic [2:0]       light_farm,
    output logic             sensor,
    output logic [CNT_W-1:0] vehicle_count,
    output logic             overflow,
    output logic             illegal_light
`ifdef WAIT_TIMEOUT_EN
    ,
    output logic             wait_alarm
`endif
);

    localparam int unsigned PT_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
    localparam logic [PT_W-1:0]  PT_LAST = PT_W'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             arrive;
    logic             loop_level_unused;   // debounced level, not needed here
    logic             green, legal, run, depart;
    logic [PT_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sensor_q, sensor_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;

    loop_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .loop_raw (loop_raw),
        .arrive   (arrive),
        .level    (loop_level_unused)
    );

    assign green = (light_farm == LIGHT_GREEN);
    assign legal = green || (light_farm == LIGHT_RED) || (light_farm == LIGHT_YELLOW);
    assign run    = green && (count_q != '0);
    assign depart = run && (timer_q == PT_LAST);

    always_comb begin
        timer_d   = (run && !depart) ? timer_q + PT_W'(1) : '0;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (arrive && !depart) begin
            if (count_q == CNT_MAX) ovf_d   = 1'b1;
            else                    count_d = count_q + CNT_W'(1);
        end else if (depart && !arrive && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
        sensor_d  = (count_d != '0);
        illegal_d = illegal_q || !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            count_q   <= '0;
            sensor_q  <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            count_q   <= count_d;
            sensor_q  <= sensor_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    assign sensor        = sensor_q;
    assign vehicle_count = count_q;
    assign overflow      = ovf_q;
    assign illegal_light = illegal_q;

`ifdef WAIT_TIMEOUT_EN
    localparam int unsigned WT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WT_W-1:0] WT_MAX = WT_W'(MAX_WAIT);

    logic [WT_W-1:0] wait_q, wait_d;
    logic            alarm_q, alarm_d;

    // Counter saturates at MAX_WAIT; the alarm latches until farm green even
    // if sensor drops in the meantime.
    always_comb begin
        wait_d  = '0;
        if (sensor_q && !green)
            wait_d = (wait_q == WT_MAX) ? wait_q : wait_q + WT_W'(1);
        alarm_d = alarm_q;
        if (green)                 alarm_d = 1'b0;
        else if (wait_d == WT_MAX) alarm_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            alarm_q <= alarm_d;
        end
    end

    assign wait_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_farm_vehicle_detector.sv
module tb_farm_vehicle_detector;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       loop_raw;
    logic [2:0] light_farm;
    logic       sensor;
    logic [3:0] vehicle_count;
    logic       overflow;
    logic       illegal_light;
`ifdef WAIT_TIMEOUT_EN
    logic       wait_alarm;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    farm_vehicle_detector #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4),
        .PASS_CYCLES     (8),
        .MAX_WAIT        (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .loop_raw      (loop_raw),
        .light_farm    (light_farm),
        .sensor        (sensor),
        .vehicle_count (vehicle_count),
        .overflow      (overflow),
        .illegal_light (illegal_light)
`ifdef WAIT_TIMEOUT_EN
        ,
        .wait_alarm    (wait_alarm)
`endif
    );

    typedef struct {
        logic       loop;
        logic [2:0] light;
        int         cyc;
        int         count;
        logic       sens;
    } vec_t;

    vec_t tbl [14];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pulse();
        loop_raw = 1'b1;
        step(10);
        loop_raw = 1'b0;
        step(10);
    endtask

    initial begin
        tbl[0]  = '{1'b1, LIGHT_RED,   3,  0, 1'b0};  // 3-cycle glitch
        tbl[1]  = '{1'b0, LIGHT_RED,   10, 0, 1'b0};
        tbl[2]  = '{1'b1, LIGHT_RED,   10, 1, 1'b1};
        tbl[3]  = '{1'b0, LIGHT_RED,   10, 1, 1'b1};
        tbl[4]  = '{1'b1, LIGHT_RED,   10, 2, 1'b1};
        tbl[5]  = '{1'b0, LIGHT_RED,   10, 2, 1'b1};
        tbl[6]  = '{1'b1, LIGHT_RED,   10, 3, 1'b1};
        tbl[7]  = '{1'b0, LIGHT_RED,   10, 3, 1'b1};
        tbl[8]  = '{1'b0, LIGHT_GREEN, 7,  3, 1'b1};
        tbl[9]  = '{1'b0, LIGHT_GREEN, 1,  2, 1'b1};
        tbl[10] = '{1'b0, LIGHT_GREEN, 8,  1, 1'b1};
        tbl[11] = '{1'b0, LIGHT_GREEN, 7,  1, 1'b1};
        tbl[12] = '{1'b0, LIGHT_GREEN, 1,  0, 1'b0};
        tbl[13] = '{1'b0, LIGHT_RED,   2,  0, 1'b0};

        // Reset with a vehicle already on the loop
        rst_n      = 1'b0;
        loop_raw   = 1'b1;
        light_farm = LIGHT_RED;
        step(3);
        chk("rst_count",   vehicle_count, 0);
        chk("rst_sensor",  sensor, 0);
        chk("rst_ovf",     overflow, 0);
        chk("rst_illegal", illegal_light, 0);
`ifdef WAIT_TIMEOUT_EN
        chk("rst_alarm",   wait_alarm, 0);
`endif
        rst_n = 1'b1;
        step(5);
        chk("rel_edge5_count", vehicle_count, 0);
        step(1);
        chk("rel_edge6_count", vehicle_count, 1);
        chk("rel_edge6_sensor", sensor, 1);
        loop_raw = 1'b0;
        step(10);
        light_farm = LIGHT_GREEN;
        step(8);
        chk("rel_drain_count", vehicle_count, 0);
        chk("rel_drain_sensor", sensor, 0);
        light_farm = LIGHT_RED;
        step(1);

        // Glitch rejection, queue and retire
        for (int i = 0; i < 14; i++) begin
            loop_raw   = tbl[i].loop;
            light_farm = tbl[i].light;
            step(tbl[i].cyc);
            chk($sformatf("tbl%0d_count", i), vehicle_count, tbl[i].count);
            chk($sformatf("tbl%0d_sensor", i), sensor, tbl[i].sens);
        end

        // Saturation
        for (int i = 0; i < 15; i++) pulse();
        chk("sat15_count", vehicle_count, 15);
        chk("sat15_ovf", overflow, 0);
        pulse();
        chk("sat16_count", vehicle_count, 15);
        chk("sat16_ovf", overflow, 1);
        light_farm = LIGHT_GREEN;
        step(120);
        chk("sat_drain_count", vehicle_count, 0);
        chk("sat_drain_sensor", sensor, 0);
        chk("sat_drain_ovf", overflow, 1);
        light_farm = LIGHT_RED;
        step(2);

        // Arrival on the same edge as pass-timer terminal
        pulse();
        pulse();
        chk("sim_pre_count", vehicle_count, 2);
        light_farm = LIGHT_GREEN;
        step(2);
        loop_raw = 1'b1;
        step(5);
        chk("sim_edge7_count", vehicle_count, 2);
        step(1);
        chk("sim_edge8_count", vehicle_count, 2);
        step(8);
        chk("sim_edge16_count", vehicle_count, 1);
        loop_raw = 1'b0;
        step(8);
        chk("sim_edge24_count", vehicle_count, 0);
        light_farm = LIGHT_RED;
        step(10);

        // Starvation wait: count=1, farm red
        pulse();
        chk("wait_count", vehicle_count, 1);
`ifdef WAIT_TIMEOUT_EN
        chk("wait_alarm_early", wait_alarm, 0);
`endif
        step(60);
`ifdef WAIT_TIMEOUT_EN
        chk("wait_alarm_set", wait_alarm, 1);
`endif
        light_farm = LIGHT_GREEN;
        step(1);
`ifdef WAIT_TIMEOUT_EN
        chk("wait_alarm_clr", wait_alarm, 0);
`endif
        step(7);
        chk("wait_drain_count", vehicle_count, 0);
        light_farm = LIGHT_RED;
        step(2);

        // Illegal light code: flagged, treated as not green
        pulse();
        chk("ill_pre_flag", illegal_light, 0);
        light_farm = 3'b011;
        step(20);
        chk("ill_flag", illegal_light, 1);
        chk("ill_count", vehicle_count, 1);
        chk("ill_sensor", sensor, 1);
        light_farm = LIGHT_RED;
        step(2);
        chk("ill_sticky", illegal_light, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
